// File: rtl/htpa_pkg.sv
// Shared widths, default frame limits and controller state encoding for the
// HTPA region-of-interest scan path.
package htpa_pkg;

    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int DCROSS_W = 9;
    localparam int GAP_W    = 2;

    localparam int X_MAX_DEF = 79;
    localparam int Y_MAX_DEF = 63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/htpa_roi_expand.sv
// Combinational search-window builder: derives the gap from dcross, widens
// the box by it and clamps every edge to the sensor frame.
module htpa_roi_expand
    import htpa_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF
) (
    input  logic [X_W-1:0]      xo,
    input  logic [X_W-1:0]      xn,
    input  logic [Y_W-1:0]      yo,
    input  logic [Y_W-1:0]      yn,
    input  logic [DCROSS_W-1:0] dcross,
    output logic [X_W-1:0]      wxo,
    output logic [X_W-1:0]      wxn,
    output logic [Y_W-1:0]      wyo,
    output logic [Y_W-1:0]      wyn
);

    localparam logic [X_W-1:0] XM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

    logic [GAP_W-1:0] gap;
    logic [X_W-1:0]   gap_x, xlo;
    logic [Y_W-1:0]   gap_y, ylo;
    logic [X_W:0]     xsum;
    logic [Y_W:0]     ysum;
    logic             unused_dcross;

    assign unused_dcross = ^dcross[DCROSS_W-2:GAP_W];

    always_comb begin
        gap   = dcross[DCROSS_W-1] ? '0 : dcross[GAP_W-1:0];
        gap_x = {{(X_W-GAP_W){1'b0}}, gap};
        gap_y = {{(Y_W-GAP_W){1'b0}}, gap};
        xlo   = (gap_x <= xo) ? xo - gap_x : '0;
        ylo   = (gap_y <= yo) ? yo - gap_y : '0;
        // One extra bit keeps xn+gap from wrapping before the clamp.
        xsum  = {1'b0, xn} + {1'b0, gap_x};
        ysum  = {1'b0, yn} + {1'b0, gap_y};
        // Low edges are clamped as well so an off-frame box still yields a
        // window the raster scan can terminate on.
        wxo   = (xlo > XM) ? XM : xlo;
        wyo   = (ylo > YM) ? YM : ylo;
        wxn   = (xsum > {1'b0, XM}) ? XM : xsum[X_W-1:0];
        wyn   = (ysum > {1'b0, YM}) ? YM : ysum[Y_W-1:0];
    end

endmodule

// File: rtl/htpa_roi_scan_ctrl.sv
// Accepts one object box, widens it into a search window and raster-scans
// that window as a valid/ready stream of pixel coordinates.
module htpa_roi_scan_ctrl
    import htpa_pkg::*;
#(
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [6:0]    req_xo,
    input  logic [6:0]    req_xn,
    input  logic [5:0]    req_yo,
    input  logic [5:0]    req_yn,
    input  logic [8:0]    req_dcross,
    input  logic          abort,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [6:0]    pix_x,
    output logic [5:0]    pix_y,
    output logic          pix_first,
    output logic          pix_last,
    output logic [6:0]    win_xo,
    output logic [6:0]    win_xn,
    output logic [5:0]    win_yo,
    output logic [5:0]    win_yn,
    output logic          busy,
    output logic          done,
    output logic          err_box
);

    state_t              state;
    logic [X_W-1:0]      l_xo, l_xn, e_wxo, e_wxn, nx;
    logic [Y_W-1:0]      l_yo, l_yn, e_wyo, e_wyn, ny;
    logic [DCROSS_W-1:0] l_dcross;

    htpa_roi_expand #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_expand (
        .xo     (l_xo),
        .xn     (l_xn),
        .yo     (l_yo),
        .yn     (l_yn),
        .dcross (l_dcross),
        .wxo    (e_wxo),
        .wxn    (e_wxn),
        .wyo    (e_wyo),
        .wyn    (e_wyn)
    );

    // Next raster position after the current pixel is accepted.
    always_comb begin
        nx = pix_x;
        ny = pix_y;
        if (pix_x < win_xn) begin
            nx = pix_x + 7'd1;
        end else begin
            nx = win_xo;
            ny = pix_y + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_first <= 1'b0;
            pix_last  <= 1'b0;
            win_xo    <= '0;
            win_xn    <= '0;
            win_yo    <= '0;
            win_yn    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_box   <= 1'b0;
            l_xo      <= '0;
            l_xn      <= '0;
            l_yo      <= '0;
            l_yn      <= '0;
            l_dcross  <= '0;
        end else begin
            done    <= 1'b0;
            err_box <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        l_xo     <= req_xo;
                        l_xn     <= req_xn;
                        l_yo     <= req_yo;
                        l_yn     <= req_yn;
                        l_dcross <= req_dcross;
                        if (req_xo > req_xn || req_yo > req_yn) begin
                            err_box <= 1'b1;
                        end else begin
                            state     <= ST_CALC;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        win_xo    <= e_wxo;
                        win_xn    <= e_wxn;
                        win_yo    <= e_wyo;
                        win_yn    <= e_wyn;
                        pix_x     <= e_wxo;
                        pix_y     <= e_wyo;
                        pix_first <= 1'b1;
                        pix_last  <= (e_wxo == e_wxn) && (e_wyo == e_wyn);
                        pix_valid <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // abort wins over an accept in the same cycle
                    if (abort) begin
                        state     <= ST_IDLE;
                        pix_valid <= 1'b0;
                        pix_first <= 1'b0;
                        pix_last  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (pix_ready) begin
                        if (pix_last) begin
                            state     <= ST_DONE;
                            pix_valid <= 1'b0;
                            pix_first <= 1'b0;
                            pix_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            pix_x     <= nx;
                            pix_y     <= ny;
                            pix_first <= (nx == win_xo) && (ny == win_yo);
                            pix_last  <= (nx == win_xn) && (ny == win_yn);
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
